// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Contents: FSM state encoding, instruction classes, control field codes,
// fault codes, and opcode match patterns (value + care mask) with a match helper.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ClsIllegal = 3'd0,
        ClsAlu     = 3'd1,  // R-type, immediate, MOVK: EXEC -> WB
        ClsLoad    = 3'd2,
        ClsStore   = 3'd3,
        ClsBranch  = 3'd4,  // B, CBZ, CBNZ, B.cond, BR: retire in EXEC
        ClsBl      = 3'd5   // link write happens in WB
    } instr_class_e;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpPassB = 2'b01;
    localparam logic [1:0] AluOpRtype = 2'b10;
    localparam logic [1:0] AluOpImm   = 2'b11;

    localparam logic [2:0] BrNone  = 3'b000;
    localparam logic [2:0] BrB     = 3'b001;
    localparam logic [2:0] BrCbz   = 3'b010;
    localparam logic [2:0] BrCbnz  = 3'b011;
    localparam logic [2:0] BrBcond = 3'b100;
    localparam logic [2:0] BrBr    = 3'b101;
    localparam logic [2:0] BrBl    = 3'b110;

    localparam logic [1:0] M2rAlu    = 2'b00;
    localparam logic [1:0] M2rMem    = 2'b01;
    localparam logic [1:0] M2rPcIncr = 2'b10;
    localparam logic [1:0] M2rMovk   = 2'b11;

    localparam logic [1:0] FaultNone     = 2'b00;
    localparam logic [1:0] FaultIllegal  = 2'b01;
    localparam logic [1:0] FaultImemTout = 2'b10;
    localparam logic [1:0] FaultDmemTout = 2'b11;

    // Fully specified opcodes
    localparam logic [10:0] OpAdd  = 11'b10001011000;
    localparam logic [10:0] OpSub  = 11'b11001011000;
    localparam logic [10:0] OpAnd  = 11'b10001010000;
    localparam logic [10:0] OpOrr  = 11'b10101010000;
    localparam logic [10:0] OpAdds = 11'b10101011000;
    localparam logic [10:0] OpSubs = 11'b11101011000;
    localparam logic [10:0] OpLdur = 11'b11111000010;
    localparam logic [10:0] OpStur = 11'b11111000000;
    localparam logic [10:0] OpBr   = 11'b11010110000;

    // Partially specified opcodes: value plus care mask (1 = bit must match)
    localparam logic [10:0] OpAddiVal  = 11'b10010001000;
    localparam logic [10:0] OpSubiVal  = 11'b11010001000;
    localparam logic [10:0] OpImmCare  = 11'b11111111110;
    localparam logic [10:0] OpMovkVal  = 11'b11110010100;
    localparam logic [10:0] OpMovkCare = 11'b11111111100;
    localparam logic [10:0] OpCbzVal   = 11'b10110100000;
    localparam logic [10:0] OpCbnzVal  = 11'b10110101000;
    localparam logic [10:0] OpBcondVal = 11'b01010100000;
    localparam logic [10:0] OpCondCare = 11'b11111111000;
    localparam logic [10:0] OpBVal     = 11'b00010100000;
    localparam logic [10:0] OpBlVal    = 11'b10010100000;
    localparam logic [10:0] OpJmpCare  = 11'b11111100000;

    function automatic logic op_match(input logic [10:0] op, input logic [10:0] val,
                                      input logic [10:0] care);
        return ((op ^ val) & care) == 11'b0;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode decoder for the multi-cycle control unit.
// Ports:
//   op         in   11  opcode to classify
//   cls        out   3  instruction class (instr_class_e encoding)
//   legal      out   1  opcode matched a supported instruction
//   alu_op     out   2  ALUOp field used in EXEC
//   alu_src    out   1  ALUSrc field used in EXEC
//   reg2loc    out   1  Reg2Loc field used in EXEC
//   sreg_up    out   1  NZCV update (ADDS/SUBS)
//   branch_op  out   3  BranchOp code for the instruction
//   mem_to_reg out   2  MemtoReg selection used in WB
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [10:0] op,
    output logic [2:0]  cls,
    output logic        legal,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic        reg2loc,
    output logic        sreg_up,
    output logic [2:0]  branch_op,
    output logic [1:0]  mem_to_reg
);

    always_comb begin
        cls        = ClsIllegal;
        alu_op     = AluOpAdd;
        alu_src    = 1'b0;
        reg2loc    = 1'b0;
        sreg_up    = 1'b0;
        branch_op  = BrNone;
        mem_to_reg = M2rAlu;

        if (op == OpAdd || op == OpSub || op == OpAnd || op == OpOrr ||
            op == OpAdds || op == OpSubs) begin
            cls     = ClsAlu;
            alu_op  = AluOpRtype;
            sreg_up = (op == OpAdds) || (op == OpSubs);
        end else if (op == OpLdur) begin
            cls        = ClsLoad;
            alu_src    = 1'b1;
            mem_to_reg = M2rMem;
        end else if (op == OpStur) begin
            cls     = ClsStore;
            alu_src = 1'b1;
            reg2loc = 1'b1;
        end else if (op_match(op, OpAddiVal, OpImmCare) ||
                     op_match(op, OpSubiVal, OpImmCare)) begin
            cls     = ClsAlu;
            alu_op  = AluOpImm;
            alu_src = 1'b1;
        end else if (op_match(op, OpMovkVal, OpMovkCare)) begin
            // MOVK reads the old Rd through the second port for the merge
            cls        = ClsAlu;
            alu_op     = AluOpImm;
            alu_src    = 1'b1;
            reg2loc    = 1'b1;
            mem_to_reg = M2rMovk;
        end else if (op_match(op, OpCbzVal, OpCondCare)) begin
            cls       = ClsBranch;
            alu_op    = AluOpPassB;
            reg2loc   = 1'b1;
            branch_op = BrCbz;
        end else if (op_match(op, OpCbnzVal, OpCondCare)) begin
            cls       = ClsBranch;
            alu_op    = AluOpPassB;
            reg2loc   = 1'b1;
            branch_op = BrCbnz;
        end else if (op_match(op, OpBcondVal, OpCondCare)) begin
            cls       = ClsBranch;
            branch_op = BrBcond;
        end else if (op_match(op, OpBVal, OpJmpCare)) begin
            cls       = ClsBranch;
            branch_op = BrB;
        end else if (op_match(op, OpBlVal, OpJmpCare)) begin
            cls        = ClsBl;
            branch_op  = BrBl;
            mem_to_reg = M2rPcIncr;
        end else if (op == OpBr) begin
            cls       = ClsBranch;
            branch_op = BrBr;
        end

        legal = (cls != ClsIllegal);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, stalls on
// memory ready handshakes with a watchdog, traps on illegal opcodes and
// memory timeouts, and counts retired instructions.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   opcode                 inst[31:21] from the instruction register
//   imem_ready, dmem_ready memory handshakes
//   IRWrite .. MemtoReg    datapath control outputs
//   halted, fault          sticky trap indicator and cause
//   retired                retired-instruction count (wraps)
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             Reg2Loc,
    output logic             WRegLoc,
    output logic [1:0]       ALUOp,
    output logic             ALUSrc,
    output logic [2:0]       BranchOp,
    output logic             SregUp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       MemtoReg,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [10:0]       op_q, op_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [1:0]        fault_q, fault_d;
    logic [CNT_W-1:0]  retired_q;
    logic              retire;

    logic [10:0] dec_op;
    logic [2:0]  dec_cls;
    logic        dec_legal;
    logic [1:0]  dec_alu_op;
    logic        dec_alu_src;
    logic        dec_reg2loc;
    logic        dec_sreg_up;
    logic [2:0]  dec_branch_op;
    logic [1:0]  dec_mem_to_reg;

    // The legality decision in DECODE needs the opcode before op_q holds it;
    // every other state decodes the registered copy, so outputs never see opcode.
    assign dec_op = (state_q == StDecode) ? opcode : op_q;

    multicycle_ctrl_decode u_decode (
        .op         (dec_op),
        .cls        (dec_cls),
        .legal      (dec_legal),
        .alu_op     (dec_alu_op),
        .alu_src    (dec_alu_src),
        .reg2loc    (dec_reg2loc),
        .sreg_up    (dec_sreg_up),
        .branch_op  (dec_branch_op),
        .mem_to_reg (dec_mem_to_reg)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            op_q      <= '0;
            wait_q    <= '0;
            fault_q   <= FaultNone;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
            retired_q <= retired_q + CNT_W'(retire);
        end
    end

    // Next-state logic; wait_d defaults to zero so any state change clears it
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = '0;
        fault_d = fault_q;
        retire  = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    state_d = StDecode;
                end else if (wait_q == WaitLast) begin
                    state_d = StTrap;
                    fault_d = FaultImemTout;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDecode: begin
                op_d = opcode;
                if (!dec_legal) begin
                    state_d = StTrap;
                    fault_d = FaultIllegal;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (dec_cls == ClsBranch) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (dec_cls == ClsLoad || dec_cls == ClsStore) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ready) begin
                    if (dec_cls == ClsStore) begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_q == WaitLast) begin
                    state_d = StTrap;
                    fault_d = FaultDmemTout;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StTrap;
            end
        endcase
    end

    // Output decode from registered state and op_q
    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        Reg2Loc  = 1'b0;
        WRegLoc  = 1'b0;
        ALUOp    = AluOpAdd;
        ALUSrc   = 1'b0;
        BranchOp = BrNone;
        SregUp   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = M2rAlu;
        halted   = (state_q == StTrap);
        fault    = fault_q;
        retired  = retired_q;

        unique case (state_q)
            StFetch: begin
                IRWrite = imem_ready;
            end
            StExec: begin
                ALUOp   = dec_alu_op;
                ALUSrc  = dec_alu_src;
                Reg2Loc = dec_reg2loc;
                SregUp  = dec_sreg_up;
                if (dec_cls == ClsBranch) begin
                    BranchOp = dec_branch_op;
                    PCWrite  = 1'b1;
                end
            end
            StMem: begin
                MemRead  = (dec_cls == ClsLoad);
                MemWrite = (dec_cls == ClsStore);
                PCWrite  = (dec_cls == ClsStore) && dmem_ready;
            end
            StWb: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                MemtoReg = dec_mem_to_reg;
                if (dec_cls == ClsBl) begin
                    WRegLoc  = 1'b1;
                    BranchOp = dec_branch_op;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instruction streams compared cycle by cycle against an instruction-level model.
module tb_multicycle_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam int K_ILL = 0, K_ALU = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_BL = 5;

    typedef struct packed {
        logic       irw, pcw, rw, r2l, wrl;
        logic [1:0] aop;
        logic       asrc;
        logic [2:0] bop;
        logic       sreg, mr, mw;
        logic [1:0] m2r;
        logic       halt;
        logic [1:0] flt;
    } ctl_t;

    typedef struct packed {
        logic [2:0] kind;
        logic [1:0] aop;
        logic       asrc, r2l, sreg;
        logic [2:0] bop;
        logic [1:0] m2r;
    } info_t;

    logic        clk, rst_n, imem_ready, dmem_ready;
    logic [10:0] opcode;
    logic        IRWrite, PCWrite, RegWrite, Reg2Loc, WRegLoc, ALUSrc, SregUp;
    logic        MemRead, MemWrite, halted;
    logic [1:0]  ALUOp, MemtoReg, fault;
    logic [2:0]  BranchOp;
    logic [31:0] retired;
    logic [18:0] ctrl_vec;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ret = 0;

    logic [10:0] pat_base [16] = '{
        11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
        11'b10101011000, 11'b11101011000, 11'b11111000010, 11'b11111000000,
        11'b10010001000, 11'b11010001000, 11'b11110010100, 11'b10110100000,
        11'b10110101000, 11'b01010100000, 11'b00010100000, 11'b10010100000};
    logic [10:0] pat_mask [16] = '{
        11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000,
        11'h001, 11'h001, 11'h003, 11'h007, 11'h007, 11'h007, 11'h01f, 11'h01f};

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .Reg2Loc    (Reg2Loc),
        .WRegLoc    (WRegLoc),
        .ALUOp      (ALUOp),
        .ALUSrc     (ALUSrc),
        .BranchOp   (BranchOp),
        .SregUp     (SregUp),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    assign ctrl_vec = {IRWrite, PCWrite, RegWrite, Reg2Loc, WRegLoc, ALUOp, ALUSrc, BranchOp,
                       SregUp, MemRead, MemWrite, MemtoReg, halted, fault};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level reference: what each opcode asks of the datapath
    function automatic info_t model(input logic [10:0] op);
        info_t r;
        r = '0;
        if (op == 11'b10001011000 || op == 11'b11001011000 || op == 11'b10001010000 ||
            op == 11'b10101010000) begin
            r.kind = K_ALU; r.aop = 2'b10;
        end else if (op == 11'b10101011000 || op == 11'b11101011000) begin
            r.kind = K_ALU; r.aop = 2'b10; r.sreg = 1'b1;
        end else if (op == 11'b11111000010) begin
            r.kind = K_LD; r.asrc = 1'b1; r.m2r = 2'b01;
        end else if (op == 11'b11111000000) begin
            r.kind = K_ST; r.asrc = 1'b1; r.r2l = 1'b1;
        end else if (op ==? 11'b1001000100? || op ==? 11'b1101000100?) begin
            r.kind = K_ALU; r.aop = 2'b11; r.asrc = 1'b1;
        end else if (op ==? 11'b111100101??) begin
            r.kind = K_ALU; r.aop = 2'b11; r.asrc = 1'b1; r.r2l = 1'b1; r.m2r = 2'b11;
        end else if (op ==? 11'b10110100???) begin
            r.kind = K_BR; r.aop = 2'b01; r.r2l = 1'b1; r.bop = 3'b010;
        end else if (op ==? 11'b10110101???) begin
            r.kind = K_BR; r.aop = 2'b01; r.r2l = 1'b1; r.bop = 3'b011;
        end else if (op ==? 11'b01010100???) begin
            r.kind = K_BR; r.bop = 3'b100;
        end else if (op ==? 11'b000101?????) begin
            r.kind = K_BR; r.bop = 3'b001;
        end else if (op ==? 11'b100101?????) begin
            r.kind = K_BL; r.bop = 3'b110; r.m2r = 2'b10;
        end else if (op == 11'b11010110000) begin
            r.kind = K_BR; r.bop = 3'b101;
        end else begin
            r.kind = K_ILL;
        end
        return r;
    endfunction

    // One clock cycle: compare at the falling edge, advance past the rising edge
    task automatic cyc(input string tag, input ctl_t e, input bit ret);
        @(negedge clk);
        check({tag, "_ctrl"}, 32'(ctrl_vec), 32'(e));
        check({tag, "_retired"}, retired, exp_ret);
        @(posedge clk);
        #1;
        if (ret) exp_ret++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("reset_ctrl", 32'(ctrl_vec), 32'd0);
        check("reset_retired", retired, 32'd0);
        exp_ret = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic trap_and_reset(input logic [1:0] f);
        ctl_t e;
        e = '0;
        e.halt = 1'b1;
        e.flt = f;
        for (int k = 0; k < 4; k++) begin
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            opcode = 11'($urandom);
            cyc("trap", e, 1'b0);
        end
        do_reset();
    endtask

    task automatic run_instr(input logic [10:0] op, input int iw, input int dw, input bit abort);
        info_t m;
        ctl_t  e;
        m = model(op);
        for (int k = 0; k <= iw; k++) begin
            imem_ready = (k == iw);
            dmem_ready = 1'($urandom);
            opcode = 11'($urandom);
            e = '0;
            if (k == iw) begin
                e.irw = 1'b1;
                cyc("fetch", e, 1'b0);
            end else if (k == int'(TIMEOUT) - 1) begin
                cyc("fetch_timeout", e, 1'b0);
                trap_and_reset(2'b10);
                return;
            end else begin
                cyc("fetch_wait", e, 1'b0);
            end
        end
        opcode = op;
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        cyc("decode", '0, 1'b0);
        if (m.kind == K_ILL) begin
            trap_and_reset(2'b01);
            return;
        end
        opcode = 11'($urandom);
        e = '0;
        e.aop = m.aop; e.asrc = m.asrc; e.r2l = m.r2l; e.sreg = m.sreg;
        if (m.kind == K_BR) begin
            e.bop = m.bop;
            e.pcw = 1'b1;
        end
        cyc("exec", e, m.kind == K_BR);
        if (m.kind == K_BR) return;
        if (m.kind == K_LD || m.kind == K_ST) begin
            for (int k = 0; k <= dw; k++) begin
                dmem_ready = (k == dw);
                imem_ready = 1'($urandom);
                opcode = 11'($urandom);
                e = '0;
                e.mr = (m.kind == K_LD);
                e.mw = (m.kind == K_ST);
                if (abort && k == 1) begin
                    @(negedge clk);
                    check("mem_pre_abort_ctrl", 32'(ctrl_vec), 32'(e));
                    check("mem_pre_abort_retired", retired, exp_ret);
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check("abort_ctrl", 32'(ctrl_vec), 32'd0);
                    check("abort_retired", retired, 32'd0);
                    exp_ret = 0;
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    return;
                end
                if (k == dw) begin
                    e.pcw = (m.kind == K_ST);
                    cyc("mem_ready", e, m.kind == K_ST);
                    if (m.kind == K_ST) return;
                end else if (k == int'(TIMEOUT) - 1) begin
                    cyc("mem_timeout", e, 1'b0);
                    trap_and_reset(2'b11);
                    return;
                end else begin
                    cyc("mem_wait", e, 1'b0);
                end
            end
        end
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        opcode = 11'($urandom);
        e = '0;
        e.rw = 1'b1; e.pcw = 1'b1; e.m2r = m.m2r;
        if (m.kind == K_BL) begin
            e.wrl = 1'b1;
            e.bop = 3'b110;
        end
        cyc("wb", e, 1'b1);
    endtask

    function automatic logic [10:0] rand_op();
        int sel;
        sel = int'($urandom_range(0, 17));
        if (sel >= 16) return 11'($urandom);
        return (pat_base[sel] & ~pat_mask[sel]) | (11'($urandom) & pat_mask[sel]);
    endfunction

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 18) return r % 4;
        return int'($urandom_range(14, 18));
    endfunction

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        opcode = '0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(11'b10001011000, 0, 0, 1'b0);   // ADD
        run_instr(11'b11111000010, 0, 3, 1'b0);   // LDUR, 3 data wait cycles
        run_instr(11'b10110101101, 0, 0, 1'b0);   // CBNZ
        run_instr(11'b11110010110, 1, 0, 1'b0);   // MOVK
        run_instr(11'b10010111111, 0, 0, 1'b0);   // BL
        run_instr(11'b11101011000, 2, 0, 1'b0);   // SUBS
        run_instr(11'b11111000000, 0, 0, 1'b0);   // STUR
        run_instr(11'b10001011000, 15, 0, 1'b0);  // ready on the last allowed fetch cycle
        run_instr(11'b11111000010, 0, 15, 1'b0);  // ready on the last allowed mem cycle
        run_instr(11'b00000000000, 0, 0, 1'b0);   // illegal -> trap, reset
        run_instr(11'b10001011000, 16, 0, 1'b0);  // imem timeout
        run_instr(11'b11111000000, 0, 16, 1'b0);  // dmem timeout
        run_instr(11'b11111000000, 0, 5, 1'b1);   // reset during STUR MEM wait
        run_instr(11'b10001011000, 0, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            run_instr(rand_op(), rand_wait(), rand_wait(), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit directly upstream of the datapath: consumes `opcode` from the instruction register and produces every datapath control input (RegWrite … MemtoReg), plus PC/IR write enables.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Stalls on instruction- and data-memory ready handshakes, bounded by a watchdog.
- Traps on illegal opcodes and counts retired instructions.

Parameters:
- TIMEOUT, 16: max wait cycles for imem_ready/dmem_ready before a fault (must be ≥ 1).
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  11  inst[31:21] from the datapath instruction register
- imem_ready  in  1  instruction memory data valid this cycle
- dmem_ready  in  1  data memory access complete this cycle
- IRWrite  out  1  load instruction register
- PCWrite  out  1  update PC (select per BranchOp/PCSrc)
- RegWrite  out  1  register file write
- Reg2Loc  out  1  1 = 2nd read reg from inst[4:0] (STUR/CBZ/CBNZ/MOVK)
- WRegLoc  out  1  1 = write reg X30 (BL)
- ALUOp  out  2  00 add, 01 pass-B/zero test, 10 R-type funct, 11 immediate
- ALUSrc  out  1  1 = ex_data as ALU operand B
- BranchOp  out  3  000 none, 001 B, 010 CBZ, 011 CBNZ, 100 B.cond, 101 BR, 110 BL
- SregUp  out  1  update NZCV (ADDS/SUBS)
- MemRead  out  1  data memory read
- MemWrite  out  1  data memory write
- MemtoReg  out  2  00 ALUOut, 01 mem, 10 pc_incr, 11 MOVK merge
- halted  out  1  sticky trap indicator
- fault  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
- retired  out  CNT_W  instructions completed

Behaviour:
- Reset (async, rst_n low):
  - state = FETCH; all control outputs 0; halted = 0; fault = 00; retired = 0; wait counter = 0.
- Outputs: Moore-style, decoded from the registered state and op_q. op_q is an 11-bit opcode register loaded in DECODE; no output depends combinationally on `opcode`.
- FETCH:
  - IRWrite = imem_ready.
  - On imem_ready -> DECODE.
  - Otherwise the wait counter increments; when it reaches TIMEOUT -> TRAP with fault = 10.
- DECODE:
  - Latch op_q <= opcode.
  - Decode:
    - ADD/SUB/AND/ORR/ADDS/SUBS (10001011000/11001011000/10001010000/10101010000/10101011000/11101011000)
    - LDUR 11111000010; STUR 11111000000
    - ADDI/SUBI 1001000100x/1101000100x
    - MOVK 111100101xx
    - CBZ 10110100xxx; CBNZ 10110101xxx; B.cond 01010100xxx
    - B 000101xxxxx; BL 100101xxxxx; BR 11010110000
  - Unmatched -> TRAP, fault = 01.
  - Otherwise -> EXEC.
- EXEC:
  - Drive ALUOp, ALUSrc, Reg2Loc, and SregUp (ADDS/SUBS only, one cycle).
  - Branches (B, CBZ, CBNZ, B.cond, BR): BranchOp valid, PCWrite = 1, -> FETCH (retire).
  - LDUR/STUR -> MEM; everything else -> WB.
- MEM:
  - MemRead (LDUR) or MemWrite (STUR) held until dmem_ready.
  - On ready: LDUR -> WB; STUR asserts PCWrite and retires -> FETCH.
  - Timeout as in FETCH -> TRAP, fault = 11; MemRead/MemWrite drop in TRAP.
- WB:
  - RegWrite = 1, PCWrite = 1 (sequential PC), -> FETCH, retire.
  - MemtoReg: 01 LDUR, 11 MOVK, 10 BL, else 00.
  - BL: WRegLoc = 1, BranchOp = 110, writes PC+4 to X30.
- TRAP: all control outputs 0, halted = 1, fault held; exit only via reset.
- Wait counter: clears on every state change; compared against TIMEOUT only in FETCH/MEM.
- Retired count: increments by 1 on each retiring cycle and wraps at 2^CNT_W.
- Cycle counts with zero-wait memories:
  - branch 3
  - R-type/imm/MOVK/BL 4
  - STUR 4
  - LDUR 5
- Ready sampled when not in FETCH/MEM: ignored.
- Reset asserted mid-instruction: immediate return to reset values; no partial write is completed.

Decomposition:
- common.vh gains:
  - state encodings (FETCH, DECODE, EXEC, MEM, WB, TRAP)
  - ALUOp, BranchOp, MemtoReg, and fault code defines
  - opcode match patterns
- One combinational sub-module, ctrl_decode: op_q -> instruction class, legal flag, static fields (ALUSrc, Reg2Loc, SregUp, BranchOp, MemtoReg).
- multicycle_ctrl holds the FSM, wait counter and retire counter.

Test Plan:
- ADD (opcode 10001011000), imem_ready/dmem_ready tied 1 -> IRWrite cycle 1; WB in cycle 4 with RegWrite = 1, PCWrite = 1, MemtoReg = 00; retired 0→1.
- LDUR with dmem_ready low for 3 MEM cycles -> MemRead held 4 cycles; then WB with MemtoReg = 01; total 8 cycles.
- CBNZ 10110101xxx -> EXEC has BranchOp = 011, Reg2Loc = 1, PCWrite = 1; RegWrite never asserted; back in FETCH after 3 cycles.
- Illegal opcode 00000000000 -> TRAP after DECODE; halted = 1, fault = 01, all controls 0 indefinitely; rst_n pulse restores reset values.
- imem_ready low for TIMEOUT = 16 cycles -> fault = 10, halted = 1; with imem_ready rising at cycle 15 instead -> normal DECODE.
- rst_n asserted during STUR MEM wait -> MemWrite drops asynchronously; retired unchanged at 0 and no increment.
